// File: rtl/ql_timing_pkg.sv
// Shared types and default geometry for the QL main-RAM contention model.
// Holds the access FSM state encoding, the ZX8301-like default slot
// geometry and small width helpers used by the other files.
package ql_timing_pkg;

  // Access sequencer states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } ql_state_e;

  // Default slot geometry: 40 chunks of 12 bus cycles per display line.
  localparam int DEF_CHUNKS_PER_LINE  = 40;
  localparam int DEF_CYCLES_PER_CHUNK = 12;
  localparam int DEF_VIDEO_CHUNKS     = 32;
  localparam int DEF_REFRESH_CHUNKS   = 8;

  // Extra bus cycles charged for the second byte of a split 16-bit access.
  localparam int DEF_RD_EXTRA = 8;
  localparam int DEF_WR_EXTRA = 10;

  // $clog2 that never yields a zero-width vector.
  function automatic int clog2_min1(input int value);
    return ($clog2(value) < 1) ? 1 : $clog2(value);
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ql_ram_contention_if.sv
// CPU-side bus signals seen by the RAM contention model.
// master: the CPU bus decoder driving strobes and qualifiers.
// slave:  the contention model answering with the DTACK delay.
interface ql_ram_contention_if;

  logic cpu_uds;          // upper data strobe
  logic cpu_lds;          // lower data strobe
  logic cpu_rw;           // 1 = read
  logic cpu_rom;          // ROM access, never contended
  logic cpu_exp;          // expansion-RAM access, never contended
  logic ram_delay_dtack;  // 1 = withhold DTACK

  modport master (
    output cpu_uds,
    output cpu_lds,
    output cpu_rw,
    output cpu_rom,
    output cpu_exp,
    input  ram_delay_dtack
  );

  modport slave (
    input  cpu_uds,
    input  cpu_lds,
    input  cpu_rw,
    input  cpu_rom,
    input  cpu_exp,
    output ram_delay_dtack
  );

endinterface

// File: rtl/ql_slot_counter.sv
// Display-line slot geometry for the RAM contention model.
// Tracks the chunk/cycle position within the line, realigns on
// hsync_start and reports whether the current bus cycle is free for the CPU.
module ql_slot_counter
  import ql_timing_pkg::*;
#(
  parameter int CHUNKS_PER_LINE  = DEF_CHUNKS_PER_LINE,
  parameter int CYCLES_PER_CHUNK = DEF_CYCLES_PER_CHUNK,
  parameter int VIDEO_CHUNKS     = DEF_VIDEO_CHUNKS,
  parameter int REFRESH_CHUNKS   = DEF_REFRESH_CHUNKS
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic enable,
  input  logic ce_bus_p,
  input  logic hsync_start,
  input  logic vblank,
  output logic slot_free
);

  localparam int CHUNK_W = clog2_min1(CHUNKS_PER_LINE);
  localparam int CYC_W   = clog2_min1(CYCLES_PER_CHUNK);

  localparam logic [CHUNK_W-1:0] CHUNK_LAST = CHUNK_W'(CHUNKS_PER_LINE - 1);
  localparam logic [CYC_W-1:0]   CYC_LAST   = CYC_W'(CYCLES_PER_CHUNK - 1);

  logic [CHUNK_W-1:0] chunk;
  logic [CYC_W-1:0]   cyc;
  logic [31:0]        busy;

  // Advance the slot position once per bus cycle; hsync_start snaps it to
  // the start of the line and takes priority over the normal increment.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk_sys) begin
    if (reset || !enable) begin
      chunk <= '0;
      cyc   <= '0;
    end else if (ce_bus_p) begin
      if (hsync_start) begin
        chunk <= '0;
        cyc   <= '0;
      end else if (cyc == CYC_LAST) begin
        cyc   <= '0;
        chunk <= (chunk == CHUNK_LAST) ? '0 : chunk + CHUNK_W'(1);
      end else begin
        cyc <= cyc + CYC_W'(1);
      end
    end
  end

  // Video owns the first VIDEO_CHUNKS of an active line, refresh the first
  // REFRESH_CHUNKS during vblank; cycle 0 of every chunk is always the CPU's.
  always_comb begin
    busy      = vblank ? 32'(REFRESH_CHUNKS) : 32'(VIDEO_CHUNKS);
    slot_free = (32'(chunk) >= busy) || (cyc == '0);
  end

endmodule

// File: rtl/ql_ram_contention.sv
// QL main-RAM contention model for the CPU bus.
// Withholds DTACK while the video controller owns RAM, re-arbitrating at
// every decision point and charging extra cycles for the second byte of a
// 16-bit access split on the 8-bit bus. ROM and expansion RAM pass freely.
// Optional feature macro: QL_TIMING_STATS_EN adds the stall_cycles counter
// and its stats_clr input.
module ql_ram_contention
  import ql_timing_pkg::*;
#(
  parameter int CHUNKS_PER_LINE  = DEF_CHUNKS_PER_LINE,
  parameter int CYCLES_PER_CHUNK = DEF_CYCLES_PER_CHUNK,
  parameter int VIDEO_CHUNKS     = DEF_VIDEO_CHUNKS,
  parameter int REFRESH_CHUNKS   = DEF_REFRESH_CHUNKS,
  parameter int RD_EXTRA         = DEF_RD_EXTRA,
  parameter int WR_EXTRA         = DEF_WR_EXTRA
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic enable,
  input  logic ce_bus_p,
  input  logic hsync_start,
  input  logic vblank,
  input  logic mode_8bit,
`ifdef QL_TIMING_STATS_EN
  input  logic        stats_clr,
  output logic [15:0] stall_cycles,
`endif
  ql_ram_contention_if.slave bus
);

  localparam int CNT_W = clog2_min1(max2(RD_EXTRA, WR_EXTRA) + 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  ql_state_e        state_q, state_d;
  logic             dtack_q, dtack_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             second_q, second_d;
  logic             prev_ds_q, prev_ds_d;

  logic ds;
  logic slot_free;
  logic slot_ok;

  ql_slot_counter #(
    .CHUNKS_PER_LINE  (CHUNKS_PER_LINE),
    .CYCLES_PER_CHUNK (CYCLES_PER_CHUNK),
    .VIDEO_CHUNKS     (VIDEO_CHUNKS),
    .REFRESH_CHUNKS   (REFRESH_CHUNKS)
  ) u_slot (
    .clk_sys     (clk_sys),
    .reset       (reset),
    .enable      (enable),
    .ce_bus_p    (ce_bus_p),
    .hsync_start (hsync_start),
    .vblank      (vblank),
    .slot_free   (slot_free)
  );

  assign ds      = bus.cpu_uds | bus.cpu_lds;
  assign slot_ok = slot_free | bus.cpu_rom | bus.cpu_exp;

  // DTACK delay comes straight from a flop, so no input reaches it
  // combinationally.
  assign bus.ram_delay_dtack = dtack_q;

  // Access sequencer registers; enable low holds everything in reset.
  always_ff @(posedge clk_sys) begin
    if (reset || !enable) begin
      state_q   <= IDLE;
      dtack_q   <= 1'b0;
      cnt_q     <= '0;
      second_q  <= 1'b0;
      prev_ds_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      dtack_q   <= dtack_d;
      cnt_q     <= cnt_d;
      second_q  <= second_d;
      prev_ds_q <= prev_ds_d;
    end
  end

  // Next-state logic: detect the strobe rise, count down the split-access
  // penalty, wait for a free slot, then release DTACK and hold until the
  // strobes drop. A strobe drop while waiting abandons the access.
  // NOTE: every signal driven here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    dtack_d   = dtack_q;
    cnt_d     = cnt_q;
    second_d  = second_q;
    prev_ds_d = prev_ds_q;

    if (ce_bus_p) begin
      prev_ds_d = ds;
      unique case (state_q)
        IDLE: begin
          dtack_d = 1'b0;
          if (ds && !prev_ds_q) begin
            dtack_d  = 1'b1;
            cnt_d    = CNT_ONE;
            second_d = mode_8bit && bus.cpu_uds && bus.cpu_lds;
            state_d  = WAIT;
          end
        end

        WAIT: begin
          if (!ds) begin
            dtack_d  = 1'b0;
            second_d = 1'b0;
            state_d  = IDLE;
          end else if (cnt_q != CNT_ONE) begin
            cnt_d = cnt_q - CNT_ONE;
          end else if (slot_ok) begin
            if (second_q) begin
              // First byte granted; the second byte pays its own penalty
              // and is then re-arbitrated.
              cnt_d    = bus.cpu_rw ? CNT_W'(RD_EXTRA) : CNT_W'(WR_EXTRA);
              second_d = 1'b0;
            end else begin
              dtack_d = 1'b0;
              state_d = HOLD;
            end
          end
        end

        HOLD: begin
          dtack_d = 1'b0;
          if (!ds) begin
            state_d = IDLE;
          end
        end

        default: begin
          dtack_d  = 1'b0;
          second_d = 1'b0;
          state_d  = IDLE;
        end
      endcase
    end
  end

`ifdef QL_TIMING_STATS_EN
  logic stall_event;

  assign stall_event = ce_bus_p && (state_q == WAIT) && (cnt_q == CNT_ONE) && !slot_ok;

  // Count bus cycles lost to video/refresh ownership; clear wins over
  // increment and the count sticks at all-ones.
  always_ff @(posedge clk_sys) begin
    if (reset || !enable || stats_clr) begin
      stall_cycles <= '0;
    end else if (stall_event && (stall_cycles != 16'hFFFF)) begin
      stall_cycles <= stall_cycles + 16'd1;
    end
  end
`endif

endmodule
